// File: rtl/rx_block_lock.sv
// 64b/66b receive block synchronizer: checks sync headers, declares block lock,
// requests single-bit gearbox slips on misalignment, and registers the data path.
module rx_block_lock #(
   parameter int DATA_WIDTH   = 32,
   parameter int SH_CNT_MAX   = 64,
   parameter int SH_INVLD_MAX = 16,
   parameter int SLIP_WAIT    = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_rx_data_valid,
   input  logic [1:0]            i_rx_header,
   input  logic                  i_rx_header_valid,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_data_valid,
   output logic [1:0]            o_rx_header,
   output logic                  o_rx_header_valid,
   output logic                  o_slip,
   output logic                  o_block_lock
);

   localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
   localparam logic [6:0]        CNT_MAX   = 7'(SH_CNT_MAX);
   localparam logic [4:0]        INVLD_MAX = 5'(SH_INVLD_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SLIP_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   typedef enum logic {
      ST_TEST,
      ST_SLIP_WAIT
   } state_t;

   state_t              state_reg, state_next;
   logic [6:0]          sh_cnt_reg, sh_cnt_next;
   logic [4:0]          sh_invld_cnt_reg, sh_invld_cnt_next;
   logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic                lock_reg, lock_next;
   logic                slip_reg, slip_next;

   logic [DATA_WIDTH-1:0] data_reg;
   logic                  data_valid_reg;
   logic [1:0]            header_reg;
   logic                  header_valid_reg;

   logic       header_event;
   logic       header_invalid;
   logic [6:0] nxt_cnt;
   logic [4:0] nxt_invld;

   assign header_event   = i_rx_header_valid & i_rx_data_valid;
   assign header_invalid = (i_rx_header == 2'b00) || (i_rx_header == 2'b11);
   assign nxt_cnt        = sh_cnt_reg + 7'd1;
   assign nxt_invld      = sh_invld_cnt_reg + {4'd0, header_invalid};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg        <= ST_TEST;
         sh_cnt_reg       <= '0;
         sh_invld_cnt_reg <= '0;
         wait_cnt_reg     <= '0;
         lock_reg         <= 1'b0;
         slip_reg         <= 1'b0;
      end else begin
         state_reg        <= state_next;
         sh_cnt_reg       <= sh_cnt_next;
         sh_invld_cnt_reg <= sh_invld_cnt_next;
         wait_cnt_reg     <= wait_cnt_next;
         lock_reg         <= lock_next;
         slip_reg         <= slip_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      sh_cnt_next       = sh_cnt_reg;
      sh_invld_cnt_next = sh_invld_cnt_reg;
      wait_cnt_next     = wait_cnt_reg;
      lock_next         = lock_reg;
      slip_next         = 1'b0;
      case (state_reg)
         ST_TEST: begin
            if (header_event) begin
               // Unlocked: any bad header slips; locked: only a full quota of bad headers does.
               if (header_invalid && (!lock_reg || nxt_invld == INVLD_MAX)) begin
                  lock_next         = 1'b0;
                  slip_next         = 1'b1;
                  sh_cnt_next       = '0;
                  sh_invld_cnt_next = '0;
                  wait_cnt_next     = WAIT_LOAD;
                  state_next        = ST_SLIP_WAIT;
               end else if (nxt_cnt == CNT_MAX) begin
                  if (nxt_invld == 5'd0) begin
                     lock_next = 1'b1;
                  end
                  sh_cnt_next       = '0;
                  sh_invld_cnt_next = '0;
               end else begin
                  sh_cnt_next       = nxt_cnt;
                  sh_invld_cnt_next = nxt_invld;
               end
            end
         end
         ST_SLIP_WAIT: begin
            lock_next = 1'b0;
            // Headers here straddle the gearbox realignment, so their contents are ignored.
            if (header_event) begin
               wait_cnt_next = wait_cnt_reg - WAIT_ONE;
               if (wait_cnt_reg <= WAIT_ONE) begin
                  state_next        = ST_TEST;
                  sh_cnt_next       = '0;
                  sh_invld_cnt_next = '0;
               end
            end
         end
         default: begin
            state_next = ST_TEST;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         data_reg         <= '0;
         data_valid_reg   <= 1'b0;
         header_reg       <= 2'b00;
         header_valid_reg <= 1'b0;
      end else begin
         data_valid_reg   <= i_rx_data_valid;
         header_valid_reg <= header_event;
         if (i_rx_data_valid) begin
            data_reg   <= i_rx_data;
            header_reg <= i_rx_header;
         end
      end
   end

   assign o_rx_data         = data_reg;
   assign o_rx_data_valid   = data_valid_reg;
   assign o_rx_header       = header_reg;
   assign o_rx_header_valid = header_valid_reg;
   assign o_slip            = slip_reg;
   assign o_block_lock      = lock_reg;

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed bench for rx_block_lock: lock acquisition, slip handling, windowed loss of lock,
// pass-through timing and mid-operation reset.
module tb_rx_block_lock;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [31:0] i_rx_data = '0;
   logic        i_rx_data_valid = 1'b0;
   logic [1:0]  i_rx_header = 2'b00;
   logic        i_rx_header_valid = 1'b0;
   logic [31:0] o_rx_data;
   logic        o_rx_data_valid;
   logic [1:0]  o_rx_header;
   logic        o_rx_header_valid;
   logic        o_slip;
   logic        o_block_lock;

   int errors = 0;
   int checks = 0;

   rx_block_lock dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_rx_data         (i_rx_data),
      .i_rx_data_valid   (i_rx_data_valid),
      .i_rx_header       (i_rx_header),
      .i_rx_header_valid (i_rx_header_valid),
      .o_rx_data         (o_rx_data),
      .o_rx_data_valid   (o_rx_data_valid),
      .o_rx_header       (o_rx_header),
      .o_rx_header_valid (o_rx_header_valid),
      .o_slip            (o_slip),
      .o_block_lock      (o_block_lock)
   );

   always #5 i_clk = ~i_clk;

   // Drive one beat, then return 1 time unit after the edge that captured it.
   task automatic beat(input logic [31:0] d, input logic dv, input logic [1:0] h, input logic hv);
      i_rx_data         = d;
      i_rx_data_valid   = dv;
      i_rx_header       = h;
      i_rx_header_valid = hv;
      @(posedge i_clk);
      #1;
   endtask

   task automatic hdr(input logic [1:0] h);
      beat($urandom, 1'b1, h, 1'b1);
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      beat(32'h0, 1'b0, 2'b00, 1'b0);
      beat(32'h0, 1'b0, 2'b00, 1'b0);
      i_reset = 1'b0;
   endtask

   task automatic lock_up();
      for (int i = 0; i < 64; i++) hdr((i % 2 == 0) ? 2'b01 : 2'b10);
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      beat(32'h1234_5678, 1'b1, 2'b01, 1'b1);
      beat(32'h8765_4321, 1'b1, 2'b10, 1'b1);
      checks++;
      if (o_rx_data !== 32'h0 || o_rx_data_valid !== 1'b0 || o_rx_header !== 2'b00 ||
          o_rx_header_valid !== 1'b0 || o_slip !== 1'b0 || o_block_lock !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h dv=%b hdr=%b hv=%b slip=%b lock=%b, required all 0",
                  o_rx_data, o_rx_data_valid, o_rx_header, o_rx_header_valid, o_slip, o_block_lock);
      end
      i_reset = 1'b0;
   endtask

   task automatic test_initial_lock();
      do_reset();
      for (int i = 1; i <= 64; i++) begin
         hdr((i % 2 == 0) ? 2'b10 : 2'b01);
         checks++;
         if (o_block_lock !== (i == 64) || o_slip !== 1'b0) begin
            errors++;
            $display("FAIL initial_lock event %0d: lock=%b slip=%b, required lock=%b slip=0",
                     i, o_block_lock, o_slip, (i == 64));
         end
      end
   endtask

   task automatic test_pass_through();
      beat(32'hDEAD_BEEF, 1'b1, 2'b10, 1'b1);
      checks++;
      if (o_rx_data !== 32'hDEAD_BEEF || o_rx_header !== 2'b10 ||
          o_rx_data_valid !== 1'b1 || o_rx_header_valid !== 1'b1) begin
         errors++;
         $display("FAIL pass_through: data=%h hdr=%b dv=%b hv=%b, required deadbeef 10 1 1",
                  o_rx_data, o_rx_header, o_rx_data_valid, o_rx_header_valid);
      end
      beat(32'h1234_5678, 1'b0, 2'b11, 1'b1);
      checks++;
      if (o_rx_data !== 32'hDEAD_BEEF || o_rx_header !== 2'b10 ||
          o_rx_data_valid !== 1'b0 || o_rx_header_valid !== 1'b0 || o_block_lock !== 1'b1) begin
         errors++;
         $display("FAIL pass_through_hold: data=%h hdr=%b dv=%b hv=%b lock=%b, required deadbeef 10 0 0 1",
                  o_rx_data, o_rx_header, o_rx_data_valid, o_rx_header_valid, o_block_lock);
      end
   endtask

   task automatic test_unlocked_slip();
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         hdr((i == 10) ? 2'b11 : 2'b01);
         checks++;
         if (o_slip !== (i == 10) || o_block_lock !== 1'b0) begin
            errors++;
            $display("FAIL unlocked_slip event %0d: slip=%b lock=%b, required slip=%b lock=0",
                     i, o_slip, o_block_lock, (i == 10));
         end
      end
      for (int i = 0; i < 4; i++) begin
         hdr((i % 2 == 0) ? 2'b00 : 2'b11);
         checks++;
         if (o_slip !== 1'b0 || o_block_lock !== 1'b0) begin
            errors++;
            $display("FAIL slip_wait_ignore %0d: slip=%b lock=%b, required 0 0", i, o_slip, o_block_lock);
         end
      end
      for (int i = 1; i <= 64; i++) begin
         hdr(2'b01);
         checks++;
         if (o_block_lock !== (i == 64) || o_slip !== 1'b0) begin
            errors++;
            $display("FAIL relock event %0d: lock=%b slip=%b, required lock=%b slip=0",
                     i, o_block_lock, o_slip, (i == 64));
         end
      end
   endtask

   task automatic test_invalid_window();
      do_reset();
      lock_up();
      // 15 invalids spread over one window: lock holds.
      for (int i = 0; i < 64; i++) begin
         hdr((i % 4 == 0 && i < 60) ? 2'b00 : 2'b10);
         checks++;
         if (o_block_lock !== 1'b1 || o_slip !== 1'b0) begin
            errors++;
            $display("FAIL window15 event %0d: lock=%b slip=%b, required 1 0", i, o_block_lock, o_slip);
         end
      end
      // 16 invalids in the next window: the 16th (event 60) drops lock and slips.
      for (int i = 0; i <= 60; i++) begin
         hdr((i % 4 == 0) ? 2'b11 : 2'b01);
         checks++;
         if (o_block_lock !== (i != 60) || o_slip !== (i == 60)) begin
            errors++;
            $display("FAIL window16 event %0d: lock=%b slip=%b, required lock=%b slip=%b",
                     i, o_block_lock, o_slip, (i != 60), (i == 60));
         end
      end
      hdr(2'b01);
      checks++;
      if (o_slip !== 1'b0 || o_block_lock !== 1'b0) begin
         errors++;
         $display("FAIL slip_one_cycle: slip=%b lock=%b, required 0 0", o_slip, o_block_lock);
      end
   endtask

   task automatic test_one_invalid_window();
      do_reset();
      lock_up();
      for (int i = 0; i < 128; i++) begin
         hdr((i == 20) ? 2'b11 : 2'b01);
         checks++;
         if (o_block_lock !== 1'b1 || o_slip !== 1'b0) begin
            errors++;
            $display("FAIL one_invalid_window event %0d: lock=%b slip=%b, required 1 0",
                     i, o_block_lock, o_slip);
         end
      end
   endtask

   task automatic test_ignored_header();
      do_reset();
      for (int i = 0; i < 5; i++) hdr(2'b01);
      beat(32'hCAFE_0000, 1'b0, 2'b00, 1'b1);
      checks++;
      if (o_slip !== 1'b0 || o_rx_header_valid !== 1'b0 || o_block_lock !== 1'b0) begin
         errors++;
         $display("FAIL ignored_header: slip=%b hv=%b lock=%b, required 0 0 0",
                  o_slip, o_rx_header_valid, o_block_lock);
      end
      for (int i = 6; i <= 64; i++) begin
         hdr(2'b10);
         checks++;
         if (o_block_lock !== (i == 64) || o_slip !== 1'b0) begin
            errors++;
            $display("FAIL ignored_count event %0d: lock=%b slip=%b, required lock=%b slip=0",
                     i, o_block_lock, o_slip, (i == 64));
         end
      end
   endtask

   task automatic test_reset_in_slip_wait();
      do_reset();
      for (int i = 0; i < 3; i++) hdr(2'b01);
      hdr(2'b00);
      checks++;
      if (o_slip !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_slip: slip=%b, required 1", o_slip);
      end
      hdr(2'b01);
      i_reset = 1'b1;
      beat(32'hAAAA_5555, 1'b1, 2'b01, 1'b1);
      checks++;
      if (o_rx_data !== 32'h0 || o_rx_data_valid !== 1'b0 || o_rx_header !== 2'b00 ||
          o_rx_header_valid !== 1'b0 || o_slip !== 1'b0 || o_block_lock !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_slip_wait: data=%h dv=%b hdr=%b hv=%b slip=%b lock=%b, required all 0",
                  o_rx_data, o_rx_data_valid, o_rx_header, o_rx_header_valid, o_slip, o_block_lock);
      end
      i_reset = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         hdr(2'b01);
         checks++;
         if (o_block_lock !== (i == 64) || o_slip !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_relock event %0d: lock=%b slip=%b, required lock=%b slip=0",
                     i, o_block_lock, o_slip, (i == 64));
         end
      end
   endtask

   initial begin
      test_reset();
      test_initial_lock();
      test_pass_through();
      test_unlocked_slip();
      test_invalid_window();
      test_one_invalid_window();
      test_ignored_header();
      test_reset_in_slip_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
